// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder; 3+ cycles per op, results held until i_ready.
// Optional ADDER_ARB_OVF_EN adds a registered signed-overflow flag (o_ovf).
module adder_arbiter #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_REQ   = 4,
  parameter int REQ_IDX_W = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] i_a,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] i_b,
  input  logic [NUM_REQ-1:0]           i_cin,
  output logic [NUM_REQ-1:0]           o_grant,
  output logic                         o_valid,
  output logic [BUS_WIDTH-1:0]         o_result,
  output logic [REQ_IDX_W-1:0]         o_tag,
  input  logic                         i_ready,
`ifdef ADDER_ARB_OVF_EN
  output logic                         o_ovf,
`endif
  output logic                         o_busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state_q, state_d;
  logic [REQ_IDX_W-1:0]   ptr_q, ptr_d;
  logic [BUS_WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic                   cin_q, cin_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   valid_q, valid_d;
  logic [BUS_WIDTH-1:0]   result_q, result_d;
  logic [REQ_IDX_W-1:0]   tag_q, tag_d;
  logic [REQ_IDX_W-1:0]   winner;
  logic [BUS_WIDTH-1:0]   sum;
  logic                   carry;
`ifdef ADDER_ARB_OVF_EN
  logic                   ovf_q, ovf_d;
`endif

  // Lowest requester above the pointer wins; otherwise lowest at/below it (wrap).
  always_comb begin
    winner = ptr_q;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k] && k <= int'(ptr_q)) winner = REQ_IDX_W'(k);
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[k] && k > int'(ptr_q)) winner = REQ_IDX_W'(k);
    end
  end

  // The single shared ripple-carry adder; MSB carry-out is discarded.
  always_comb begin
    sum   = '0;
    carry = cin_q;
    for (int i = 0; i < BUS_WIDTH; i++) begin
      sum[i] = a_q[i] ^ b_q[i] ^ carry;
      carry  = (a_q[i] & b_q[i]) | (carry & (a_q[i] ^ b_q[i]));
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|i_req) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (i_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    grant_d  = '0;
    valid_d  = valid_q;
    result_d = result_q;
    tag_d    = tag_q;
`ifdef ADDER_ARB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          a_d             = i_a[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
          b_d             = i_b[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
          cin_d           = i_cin[winner];
          grant_d[winner] = 1'b1;
          ptr_d           = winner;
        end
      end
      EXEC: begin
        result_d = sum;
        tag_d    = ptr_q;
        valid_d  = 1'b1;
`ifdef ADDER_ARB_OVF_EN
        ovf_d    = (a_q[BUS_WIDTH-1] == b_q[BUS_WIDTH-1]) && (sum[BUS_WIDTH-1] != a_q[BUS_WIDTH-1]);
`endif
      end
      RESP:    if (i_ready) valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ptr_q    <= REQ_IDX_W'(NUM_REQ - 1);
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
`ifdef ADDER_ARB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      tag_q    <= tag_d;
`ifdef ADDER_ARB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_grant  = grant_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_tag    = tag_q;
  assign o_busy   = (state_q != IDLE);
`ifdef ADDER_ARB_OVF_EN
  assign o_ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios then randomized ops against a round-robin/arithmetic model.
module tb_adder_arbiter;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a, b;
  logic [N-1:0]   cin;
  logic           ready;
  logic [N-1:0]   grant;
  logic           valid;
  logic [W-1:0]   result;
  logic [IW-1:0]  tag;
  logic           busy;
`ifdef ADDER_ARB_OVF_EN
  logic           ovf;
`endif

  adder_arbiter #(.BUS_WIDTH(W), .NUM_REQ(N), .REQ_IDX_W(IW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_a(a), .i_b(b), .i_cin(cin),
    .o_grant(grant), .o_valid(valid), .o_result(result), .o_tag(tag), .i_ready(ready),
`ifdef ADDER_ARB_OVF_EN
    .o_ovf(ovf),
`endif
    .o_busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int last  = N - 1;
  int got_res, got_tag, got_ovf;

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int after);
    for (int i = 1; i <= N; i++) begin
      int c;
      c = (after + i) % N;
      if (r[c]) return c;
    end
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation from IDLE: grant, result, 'hold' stalled cycles, accept.
  task automatic run_op(input int hold, input string nm);
    int w, ea, eb, ec, es, sa, sb, exp_ovf;
    w  = pick(req, last);
    ea = int'(a[w*W +: W]);
    eb = int'(b[w*W +: W]);
    ec = int'(cin[w]);
    es = (ea + eb + ec) % (1 << W);
    sa = (ea >= (1 << (W-1))) ? ea - (1 << W) : ea;
    sb = (eb >= (1 << (W-1))) ? eb - (1 << W) : eb;
    exp_ovf = ((sa + sb + ec) > ((1 << (W-1)) - 1) || (sa + sb + ec) < -(1 << (W-1))) ? 1 : 0;
    tick();
    chk({nm, "_grant"}, 32'(grant), 32'(1) << w);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_novalid"}, 32'(valid), 32'd0);
    last = w;
    a = (N*W)'($urandom);
    b = (N*W)'($urandom);
    tick();
    chk({nm, "_valid"}, 32'(valid), 32'd1);
    chk({nm, "_result"}, 32'(result), 32'(es));
    chk({nm, "_tag"}, 32'(tag), 32'(w));
    chk({nm, "_grant_off"}, 32'(grant), 32'd0);
`ifdef ADDER_ARB_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(exp_ovf));
    got_ovf = int'(ovf);
`else
    got_ovf = exp_ovf;
`endif
    got_res = int'(result);
    got_tag = int'(tag);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({nm, "_hold_valid"}, 32'(valid), 32'd1);
      chk({nm, "_hold_result"}, 32'(result), 32'(es));
      chk({nm, "_hold_tag"}, 32'(tag), 32'(w));
      chk({nm, "_hold_nogrant"}, 32'(grant), 32'd0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk({nm, "_accept_valid"}, 32'(valid), 32'd0);
    chk({nm, "_accept_busy"}, 32'(busy), 32'd0);
    chk({nm, "_accept_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; a = '0; b = '0; cin = '0; ready = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_tag", 32'(tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_valid", 32'(valid), 32'd0);
      chk("idle_grant", 32'(grant), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Single request on requester 1
    req = 4'b0010; a[1*W +: W] = 8'h3C; b[1*W +: W] = 8'h05; cin[1] = 1'b1;
    run_op(0, "single");
    chk("single_const_res", 32'(got_res), 32'h42);
    chk("single_const_tag", 32'(got_tag), 32'd1);

    // Modular wrap-around
    req = 4'b0001; a[0 +: W] = 8'hFF; b[0 +: W] = 8'h01; cin = '0;
    run_op(0, "wrap");
    chk("wrap_const_res", 32'(got_res), 32'h00);
    req = 4'b0001; a[0 +: W] = 8'h7F; b[0 +: W] = 8'h01; cin = '0;
    run_op(0, "sovf");
    chk("sovf_const_res", 32'(got_res), 32'h80);
`ifdef ADDER_ARB_OVF_EN
    chk("sovf_const_ovf", 32'(got_ovf), 32'd1);
`endif

    // Fairness from a fresh reset
    rst_n = 1'b0; req = '0;
    tick();
    rst_n = 1'b1; last = N - 1;
    req = 4'b1111; a = (N*W)'($urandom); b = (N*W)'($urandom); cin = N'($urandom);
    for (int k = 0; k < 6; k++) begin
      run_op(0, "rr");
      chk("rr_order", 32'(got_tag), 32'(k % N));
    end

    // Backpressure with requester 2 pending
    req = 4'b1000;
    run_op(0, "pre_bp");
    req = 4'b0101;
    run_op(10, "bp");
    chk("bp_first_tag", 32'(got_tag), 32'd0);
    req = 4'b0100;
    run_op(0, "bp2");
    chk("bp2_tag", 32'(got_tag), 32'd2);

    // Reset during EXEC
    req = 4'b0001;
    tick();
    chk("mid_grant", 32'(grant), 32'b0001);
    rst_n = 1'b0;
    tick();
    chk("mid_valid", 32'(valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_grant_off", 32'(grant), 32'd0);
    chk("mid_result", 32'(result), 32'd0);
    rst_n = 1'b1; last = N - 1;
    req = 4'b1001;
    run_op(0, "post_rst");
    chk("post_rst_tag", 32'(got_tag), 32'd0);

    // Randomized operations
    for (int n = 0; n < 40; n++) begin
      req = N'($urandom_range(1, (1 << N) - 1));
      a   = (N*W)'($urandom);
      b   = (N*W)'($urandom);
      cin = N'($urandom);
      run_op(int'($urandom_range(0, 3)), "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one BUS_WIDTH ripple-carry adder instance between NUM_REQ requesters.
- Round-robin arbitration, operand capture, one addition at a time, registered result returned with the winner's tag.
- Sits between client blocks (ALU lanes, address generators) and the single shared adder datapath.

Parameters:
- BUS_WIDTH, 8, operand/result width passed to the adder instance.
- NUM_REQ, 4, number of requesters (2..16).
- REQ_IDX_W, 2, tag width; must satisfy 2^REQ_IDX_W >= NUM_REQ.

Ports:
- i_clk  input  1  single clock; all state updates on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_req  input  NUM_REQ  per-requester request; held with operands until granted.
- i_a  input  NUM_REQ*BUS_WIDTH  packed operand A; requester k uses bits [k*BUS_WIDTH +: BUS_WIDTH].
- i_b  input  NUM_REQ*BUS_WIDTH  packed operand B, same packing.
- i_cin  input  NUM_REQ  per-requester carry-in.
- o_grant  output  NUM_REQ  one-hot, one-cycle pulse: requester's operands were captured this edge.
- o_valid  output  1  result valid.
- o_result  output  BUS_WIDTH  (a + b + cin) mod 2^BUS_WIDTH.
- o_tag  output  REQ_IDX_W  index of the requester owning o_result.
- i_ready  input  1  consumer accepts result when o_valid & i_ready.
- o_busy  output  1  high whenever FSM is not IDLE.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-low.
- Reset (i_rst_n=0 at an edge, any state):
  - FSM -> IDLE.
  - o_grant=0, o_valid=0, o_result=0, o_tag=0, o_busy=0.
  - RR pointer=NUM_REQ-1, so requester 0 has top priority first.
  - In-flight operation and unaccepted result are discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any i_req=1 at an edge: pick the winner as the first set bit scanning from pointer+1 upward, wrapping modulo NUM_REQ.
  - At that edge: capture the winner's a/b/cin into operand registers, set o_grant one-hot for exactly one cycle, pointer<=winner, tag<=winner, ->EXEC.
  - No request: stay IDLE, outputs unchanged.
- EXEC:
  - Shared adder is driven combinationally from the operand registers.
  - At the edge: o_result<=adder sum, o_tag<=captured tag, o_valid<=1, ->RESP.
  - o_grant is 0.
- RESP:
  - o_valid=1; o_result/o_tag stable.
  - If i_ready=1 at an edge: o_valid<=0, ->IDLE.
  - Otherwise hold indefinitely.
  - Requests are not sampled in EXEC or RESP.
- Latency: request sampled at edge N -> o_grant high cycle N+1 -> o_valid high from cycle N+2. Minimum 3 cycles per operation; next grant no earlier than the edge after acceptance.
- Requester protocol:
  - i_req may drop before grant without side effects.
  - After the grant pulse the requester may change operands or drop i_req; captured values are used.
  - A requester holding i_req after its grant is eligible again only under RR order.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 other operations.
- Arithmetic:
  - Carry-out of the MSB is dropped; result wraps modulo 2^BUS_WIDTH.
  - cin adds 1 to the LSB.
- Simultaneous reset with i_ready or i_req: reset wins.

Optional Feature:
- Macro ADDER_ARB_OVF_EN.
- Defined:
  - Adds output o_ovf (1 bit), registered with o_result in EXEC.
  - o_ovf = two's-complement signed overflow: operand MSBs equal and result MSB differs.
  - Reset value 0; held stable in RESP.
- Undefined: port o_ovf absent; no overflow logic synthesized.

Test Plan:
- Reset then idle: hold i_rst_n=0 2 cycles, release, no requests 5 cycles -> o_valid=0, o_grant=0, o_busy=0 throughout.
- Single request: BUS_WIDTH=8, req1 with a=0x3C, b=0x05, cin=1 -> o_grant=4'b0010 one cycle after sampling; o_valid next cycle; o_result=0x42, o_tag=1.
- Wrap-around: req0 with a=0xFF, b=0x01, cin=0 -> o_result=0x00. With ADDER_ARB_OVF_EN: a=0x7F, b=0x01 -> o_result=0x80, o_ovf=1.
- Round-robin fairness: all four requesters held high, i_ready=1 -> grant order 0,1,2,3,0,1 with each tag matching its operands' sum.
- Backpressure: i_ready=0 for 10 cycles in RESP while req2 pending -> o_result/o_tag stable, no grant. Raise i_ready -> o_valid drops next cycle; req2 granted at the following edge.
- Reset mid-op: assert i_rst_n=0 during EXEC -> next cycle o_valid=0, o_busy=0. After release with req0 and req3 high, req0 is granted first.
